// File: rtl/interfaz_rx_pkg.sv
// Shared UART/ALU definitions: FSM state encoding and default datapath widths.
package interfaz_rx_pkg;

    localparam int NB_DATA_DEF = 8;
    localparam int NB_OP_DEF   = 6;

    typedef enum logic [1:0] {
        ST_A  = 2'b00,
        ST_B  = 2'b01,
        ST_OP = 2'b10
    } rx_state_t;

endpackage

// File: rtl/interfaz_rx_if.sv
// UART-receiver to ALU frame bus; master drives received bytes, slave presents frames.
interface interfaz_rx_if
    import interfaz_rx_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_OP   = NB_OP_DEF
);
    logic [NB_DATA-1:0] i_data;
    logic               i_rx_done;
    logic [NB_DATA-1:0] o_dato_a;
    logic [NB_DATA-1:0] o_dato_b;
    logic [NB_OP-1:0]   o_opcode;
    logic               o_start_alu;
    logic               o_timeout;
    logic               o_busy;

    modport master (
        output i_data, i_rx_done,
        input  o_dato_a, o_dato_b, o_opcode, o_start_alu, o_timeout, o_busy
    );

    modport slave (
        input  i_data, i_rx_done,
        output o_dato_a, o_dato_b, o_opcode, o_start_alu, o_timeout, o_busy
    );
endinterface

// File: rtl/interfaz_rx.sv
// Assembles A, B, opcode bytes into one registered ALU frame with a start pulse (1 cycle latency).
// No backpressure: bytes are accepted whenever i_rx_done pulses; partial frames are dropped after TIMEOUT idle cycles.
module interfaz_rx
    import interfaz_rx_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_OP   = NB_OP_DEF,
    parameter int TIMEOUT = 1000,
    parameter int NB_TOUT = 10
) (
    input  logic          i_clk,
    input  logic          i_rst,
    interfaz_rx_if.slave  bus
);

    localparam logic [NB_TOUT-1:0] TOUT_LAST = NB_TOUT'(TIMEOUT - 1);

    rx_state_t          state_q, state_d;
    logic [NB_TOUT-1:0] cnt_q, cnt_d;
    logic [NB_DATA-1:0] shadow_a_q, shadow_a_d;
    logic [NB_DATA-1:0] shadow_b_q, shadow_b_d;
    logic [NB_DATA-1:0] dato_a_q, dato_a_d;
    logic [NB_DATA-1:0] dato_b_q, dato_b_d;
    logic [NB_OP-1:0]   opcode_q, opcode_d;
    logic               start_q, start_d;
    logic               tout_q, tout_d;
    logic               busy_q, busy_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shadow_a_d = shadow_a_q;
        shadow_b_d = shadow_b_q;
        dato_a_d   = dato_a_q;
        dato_b_d   = dato_b_q;
        opcode_d   = opcode_q;
        start_d    = 1'b0;
        tout_d     = 1'b0;

        case (state_q)
            ST_A: begin
                cnt_d = '0;
                if (bus.i_rx_done) begin
                    shadow_a_d = bus.i_data;
                    state_d    = ST_B;
                end
            end
            ST_B: begin
                // A byte arriving on the last counted cycle still wins over the timeout.
                if (bus.i_rx_done) begin
                    shadow_b_d = bus.i_data;
                    cnt_d      = '0;
                    state_d    = ST_OP;
                end else if (cnt_q == TOUT_LAST) begin
                    cnt_d   = '0;
                    tout_d  = 1'b1;
                    state_d = ST_A;
                end else begin
                    cnt_d = cnt_q + NB_TOUT'(1);
                end
            end
            ST_OP: begin
                if (bus.i_rx_done) begin
                    dato_a_d = shadow_a_q;
                    dato_b_d = shadow_b_q;
                    opcode_d = bus.i_data[NB_OP-1:0];
                    start_d  = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_A;
                end else if (cnt_q == TOUT_LAST) begin
                    cnt_d   = '0;
                    tout_d  = 1'b1;
                    state_d = ST_A;
                end else begin
                    cnt_d = cnt_q + NB_TOUT'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_A;
            end
        endcase

        busy_d = (state_d == ST_B) || (state_d == ST_OP);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_A;
            cnt_q      <= '0;
            shadow_a_q <= '0;
            shadow_b_q <= '0;
            dato_a_q   <= '0;
            dato_b_q   <= '0;
            opcode_q   <= '0;
            start_q    <= 1'b0;
            tout_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shadow_a_q <= shadow_a_d;
            shadow_b_q <= shadow_b_d;
            dato_a_q   <= dato_a_d;
            dato_b_q   <= dato_b_d;
            opcode_q   <= opcode_d;
            start_q    <= start_d;
            tout_q     <= tout_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.o_dato_a    = dato_a_q;
    assign bus.o_dato_b    = dato_b_q;
    assign bus.o_opcode    = opcode_q;
    assign bus.o_start_alu = start_q;
    assign bus.o_timeout   = tout_q;
    assign bus.o_busy      = busy_q;

endmodule

// File: doc/interfaz_rx.md
Name: interfaz_rx

Overview:
- Receive-side counterpart of the ALU→UART transmit interface.
- Collects consecutive bytes from the UART receiver: operand A, operand B, then opcode.
- Presents them to the ALU as one stable, registered frame and pulses a start strobe.
- Includes an inter-byte timeout that discards partial frames so a lost byte cannot desynchronise later frames.

Parameters:
- NB_DATA, 8, width of UART data byte and ALU operands.
- NB_OP, 6, ALU opcode width; taken from the low NB_OP bits of the third byte.
- TIMEOUT, 1000, clock cycles allowed between bytes of one frame before the partial frame is discarded (must be ≥2).
- NB_TOUT, 10, width of the timeout counter; must satisfy 2^NB_TOUT > TIMEOUT.

Ports:
- i_clk  input  1  system clock, all logic on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_data  input  NB_DATA  received byte from UART receiver; valid only when i_rx_done=1.
- i_rx_done  input  1  one-cycle pulse from UART receiver marking a new byte on i_data.
- o_dato_a  output  NB_DATA  operand A of last complete frame.
- o_dato_b  output  NB_DATA  operand B of last complete frame.
- o_opcode  output  NB_OP  opcode of last complete frame.
- o_start_alu  output  1  one-cycle pulse: new frame on outputs.
- o_timeout  output  1  one-cycle pulse: partial frame discarded.
- o_busy  output  1  high while a frame is partially received (state ST_B or ST_OP).

Behaviour:
- Reset (i_rst=1 at a clock edge): state ST_A, all shadow and output registers 0, counter 0, o_start_alu=0, o_timeout=0, o_busy=0. Reset mid-frame discards everything. Reset has priority over every other event.
- States: ST_A (wait operand A), ST_B (wait operand B), ST_OP (wait opcode).
- ST_A: on i_rx_done, capture i_data → shadow_a, counter←0, go ST_B. Otherwise stay; counter held at 0.
- ST_B: on i_rx_done, capture i_data → shadow_b, counter←0, go ST_OP.
- ST_OP, on i_rx_done, in the same edge:
  - o_dato_a←shadow_a, o_dato_b←shadow_b, o_opcode←i_data[NB_OP-1:0] (upper bits ignored).
  - o_start_alu←1 for exactly that following cycle; counter←0; go ST_A.
- Output stability: o_dato_a/o_dato_b/o_opcode change only on frame completion and hold otherwise (including across timeouts).
- Latency: o_start_alu and the new outputs are visible the cycle after the opcode's i_rx_done (1 cycle).
- Timeout, in ST_B or ST_OP without i_rx_done:
  - counter increments each cycle.
  - When counter==TIMEOUT-1 and no i_rx_done that cycle: go ST_A, counter←0, o_timeout←1 for one cycle, shadows left as-is but unused.
- Simultaneous i_rx_done and counter==TIMEOUT-1: the byte is accepted, no timeout.
- Back-to-back frames: an i_rx_done on the cycle right after the opcode byte is accepted as the new operand A (ST_A already active). o_start_alu still pulses that cycle.
- i_rx_done held high for several cycles is treated as one byte per cycle. The UART receiver guarantees single-cycle pulses; no edge detection is done here.
- o_busy = (state==ST_B)||(state==ST_OP), registered with the state.
- Widths: counter is NB_TOUT unsigned and never wraps, because it is cleared at TIMEOUT-1.

Decomposition:
- Shared UART/ALU package holds:
  - state encoding constants ST_A=2'b00, ST_B=2'b01, ST_OP=2'b10;
  - NB_DATA and NB_OP defaults, shared with the ALU and interfaz_tx.
- Unused encoding 2'b11 returns to ST_A.
- No sub-module: FSM, shadow registers and timeout counter together sit comfortably in one module of roughly 150 lines.

Test Plan:
- Normal frame: reset, then i_rx_done pulses with 8'h05, 8'h03, 8'h20 spaced 10 cycles → one cycle after the third pulse, o_dato_a=8'h05, o_dato_b=8'h03, o_opcode=6'h20, o_start_alu=1 for 1 cycle; o_busy high between the first and third byte.
- Opcode masking: frame 8'hFF, 8'h01, 8'hE2 → o_opcode=6'h22, o_dato_a=8'hFF, o_dato_b=8'h01.
- Timeout: TIMEOUT=20, send 8'h11 then nothing → o_timeout pulses 20 cycles after the byte, o_busy drops, outputs keep the previous frame. Next frame 8'h07, 8'h02, 8'h21 → outputs 07/02/21.
- Timeout boundary: byte B arrives exactly on the cycle counter==TIMEOUT-1 → no o_timeout, FSM goes to ST_OP.
- Back-to-back: two frames (01,02,20) and (0A,0B,22) with consecutive-cycle pulses → two o_start_alu pulses 3 cycles apart carrying the respective values.
- Reset mid-frame: send 8'h33, 8'h44, assert i_rst 1 cycle, then send frame 09,08,20 → all outputs 0 after reset, then 09/08/20 with one o_start_alu and no spurious pulse.
